// File: rtl/zchip_bus_seq.sv
// -----------------------------------------------------------------------------
// zchip_bus_seq
//
// Sequencer and round-robin arbiter for the shared chip-side bus that carries
// the W5300 Ethernet chip and the SL811 USB chip. The two chips share the data
// bus and the brd_n/bwr_n strobes. Each chip has its own chip select.
//
// Two requesters present byte-wide accesses:
//   r0 = ZX-bus port decoder
//   r1 = internal/test engine
// The sequencer runs one access at a time through the states
// IDLE -> SETUP -> STROBE -> HOLD -> DONE. The length of each phase is set by a
// parameter and counted in fclk cycles.
//
// Parameters (valid range 1..15 each):
//   SETUP   cycles cs_n is low before the strobe
//   STROBE  cycles brd_n/bwr_n is low
//   HOLD    cycles cs_n is low after the strobe is released
//
// Ports:
//   fclk, rst_n                 clock (posedge) and async active-low reset
//   rN_req/we/sel/addr/wdata    request from requester N (N = 0, 1)
//   rN_ack                      one-cycle completion pulse
//   rN_rdata                    read data, held until N's next read completes
//   w5300_addr, sl811_a0        registered chip addresses
//   w5300_cs_n, sl811_cs_n      chip selects
//   brd_n, bwr_n                read/write strobes
//   bd_out, bd_oe, bd_in        shared data bus: write data, drive enable,
//                               read data
//   busy                        high whenever the sequencer is not in IDLE
//
// Every output comes straight from a flop. No input reaches a strobe or a chip
// select through combinational logic.
// -----------------------------------------------------------------------------
module zchip_bus_seq #(
  parameter int unsigned SETUP  = 1,
  parameter int unsigned STROBE = 4,
  parameter int unsigned HOLD   = 1
) (
  input  logic       fclk,
  input  logic       rst_n,

  input  logic       r0_req,
  input  logic       r0_we,
  input  logic       r0_sel,
  input  logic [9:0] r0_addr,
  input  logic [7:0] r0_wdata,
  output logic       r0_ack,
  output logic [7:0] r0_rdata,

  input  logic       r1_req,
  input  logic       r1_we,
  input  logic       r1_sel,
  input  logic [9:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r1_ack,
  output logic [7:0] r1_rdata,

  output logic [9:0] w5300_addr,
  output logic       sl811_a0,
  output logic       w5300_cs_n,
  output logic       sl811_cs_n,
  output logic       brd_n,
  output logic       bwr_n,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  input  logic [7:0] bd_in,
  output logic       busy
);

  // Phase counters load "length - 1". The phase then ends on the edge where
  // the counter reads zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;   // requester favoured on contention (0 = r0)
  logic       gnt_q, gnt_d;     // requester owning the current access
  logic       we_q, we_d;

  logic [9:0] w5300_addr_q, w5300_addr_d;
  logic       sl811_a0_q, sl811_a0_d;
  logic       w5300_cs_n_q, w5300_cs_n_d;
  logic       sl811_cs_n_q, sl811_cs_n_d;
  logic       brd_n_q, brd_n_d;
  logic       bwr_n_q, bwr_n_d;
  logic [7:0] bd_out_q, bd_out_d;
  logic       bd_oe_q, bd_oe_d;
  logic       r0_ack_q, r0_ack_d;
  logic       r1_ack_q, r1_ack_d;
  logic [7:0] r0_rdata_q, r0_rdata_d;
  logic [7:0] r1_rdata_q, r1_rdata_d;
  logic       busy_q, busy_d;

  // Grant selection. With a single request that requester wins. With two
  // requests the favoured one wins.
  logic       pick;
  logic       g_we;
  logic       g_sel;
  logic [9:0] g_addr;
  logic [7:0] g_wdata;

  assign pick    = (r0_req && r1_req) ? prio_q : r1_req;
  assign g_we    = pick ? r1_we    : r0_we;
  assign g_sel   = pick ? r1_sel   : r0_sel;
  assign g_addr  = pick ? r1_addr  : r0_addr;
  assign g_wdata = pick ? r1_wdata : r0_wdata;

  always_comb begin
    // NOTE: every variable gets a hold/default value before the case
    // statement. Any path that skips an assignment then keeps its register
    // value instead of inferring a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    w5300_addr_d = w5300_addr_q;
    sl811_a0_d   = sl811_a0_q;
    w5300_cs_n_d = w5300_cs_n_q;
    sl811_cs_n_d = sl811_cs_n_q;
    brd_n_d      = brd_n_q;
    bwr_n_d      = bwr_n_q;
    bd_out_d     = bd_out_q;
    bd_oe_d      = bd_oe_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d  = pick;
          prio_d = ~pick;
          we_d   = g_we;
          if (g_sel) begin
            sl811_a0_d   = g_addr[0];
            sl811_cs_n_d = 1'b0;
          end else begin
            w5300_addr_d = g_addr;
            w5300_cs_n_d = 1'b0;
          end
          if (g_we) begin
            bd_out_d = g_wdata;
            bd_oe_d  = 1'b1;
          end
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
          if (we_q) bwr_n_d = 1'b0;
          else      brd_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          brd_n_d = 1'b1;
          bwr_n_d = 1'b1;
          // Read data is sampled on the same edge that releases brd_n.
          if (!we_q) begin
            if (gnt_q) r1_rdata_d = bd_in;
            else       r0_rdata_d = bd_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_DONE;
          w5300_cs_n_d = 1'b1;
          sl811_cs_n_d = 1'b1;
          bd_oe_d      = 1'b0;
          if (gnt_q) r1_ack_d = 1'b1;
          else       r0_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together, so no flop reads another flop's new value in the same
  // cycle.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      w5300_addr_q <= 10'd0;
      sl811_a0_q   <= 1'b0;
      w5300_cs_n_q <= 1'b1;
      sl811_cs_n_q <= 1'b1;
      brd_n_q      <= 1'b1;
      bwr_n_q      <= 1'b1;
      bd_out_q     <= 8'd0;
      bd_oe_q      <= 1'b0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_rdata_q   <= 8'd0;
      r1_rdata_q   <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      w5300_addr_q <= w5300_addr_d;
      sl811_a0_q   <= sl811_a0_d;
      w5300_cs_n_q <= w5300_cs_n_d;
      sl811_cs_n_q <= sl811_cs_n_d;
      brd_n_q      <= brd_n_d;
      bwr_n_q      <= bwr_n_d;
      bd_out_q     <= bd_out_d;
      bd_oe_q      <= bd_oe_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign w5300_addr = w5300_addr_q;
  assign sl811_a0   = sl811_a0_q;
  assign w5300_cs_n = w5300_cs_n_q;
  assign sl811_cs_n = sl811_cs_n_q;
  assign brd_n      = brd_n_q;
  assign bwr_n      = bwr_n_q;
  assign bd_out     = bd_out_q;
  assign bd_oe      = bd_oe_q;
  assign r0_ack     = r0_ack_q;
  assign r1_ack     = r1_ack_q;
  assign r0_rdata   = r0_rdata_q;
  assign r1_rdata   = r1_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_zchip_bus_seq.sv
// -----------------------------------------------------------------------------
// tb_zchip_bus_seq
//
// Directed bench for zchip_bus_seq.
//   u_dut  : default timing 1/4/1
//   u_dut2 : timing 2/1/3
// Each task issues its own accesses and then compares traces against
// hand-computed values. The capture task records one sample per cycle.
// Bit c of each mask represents cycle k+c, where edge k is the edge at which
// IDLE samples the request.
// -----------------------------------------------------------------------------
module tb_zchip_bus_seq;

  logic fclk = 1'b0;
  always #5 fclk = ~fclk;

  logic rst_n;

  // ----- DUT 1 signals (defaults) -----
  logic       r0_req, r0_we, r0_sel, r1_req, r1_we, r1_sel;
  logic [9:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_ack, r1_ack;
  logic [7:0] r0_rdata, r1_rdata;
  logic [9:0] w5300_addr;
  logic       sl811_a0, w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, busy;
  logic [7:0] bd_out, bd_in;

  // ----- DUT 2 signals (SETUP=2, STROBE=1, HOLD=3) -----
  logic       b_r0_req, b_r0_we, b_r0_sel, b_r1_req, b_r1_we, b_r1_sel;
  logic [9:0] b_r0_addr, b_r1_addr;
  logic [7:0] b_r0_wdata, b_r1_wdata;
  logic       b_r0_ack, b_r1_ack;
  logic [7:0] b_r0_rdata, b_r1_rdata;
  logic [9:0] b_w5300_addr;
  logic       b_sl811_a0, b_w5300_cs_n, b_sl811_cs_n, b_brd_n, b_bwr_n;
  logic       b_bd_oe, b_busy;
  logic [7:0] b_bd_out, b_bd_in;

  zchip_bus_seq u_dut (
    .fclk(fclk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_sel(r0_sel), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_sel(r1_sel), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .w5300_addr(w5300_addr), .sl811_a0(sl811_a0),
    .w5300_cs_n(w5300_cs_n), .sl811_cs_n(sl811_cs_n),
    .brd_n(brd_n), .bwr_n(bwr_n), .bd_out(bd_out), .bd_oe(bd_oe),
    .bd_in(bd_in), .busy(busy)
  );

  zchip_bus_seq #(.SETUP(2), .STROBE(1), .HOLD(3)) u_dut2 (
    .fclk(fclk), .rst_n(rst_n),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_sel(b_r0_sel), .r0_addr(b_r0_addr),
    .r0_wdata(b_r0_wdata), .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_sel(b_r1_sel), .r1_addr(b_r1_addr),
    .r1_wdata(b_r1_wdata), .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .w5300_addr(b_w5300_addr), .sl811_a0(b_sl811_a0),
    .w5300_cs_n(b_w5300_cs_n), .sl811_cs_n(b_sl811_cs_n),
    .brd_n(b_brd_n), .bwr_n(b_bwr_n), .bd_out(b_bd_out), .bd_oe(b_bd_oe),
    .bd_in(b_bd_in), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle traces filled by capture()
  logic [95:0] m_wcs, m_scs, m_rd, m_wr, m_oe, m_ack0, m_ack1, m_busy;
  logic [95:0] b_m_cs, b_m_rd, b_m_wr, b_m_ack;
  logic [7:0]  t_bd   [96];
  logic [7:0]  t_r0d  [96];
  logic [7:0]  t_r1d  [96];
  logic [7:0]  b_t_r0d[96];
  logic [9:0]  t_addr [96];
  logic        t_a0   [96];

  logic [7:0] rd_val;       // value the "chip" drives on bd while brd_n is low
  int rearm0 = 0;           // re-requests left after an ack, per requester
  int rearm1 = 0;
  logic pend0 = 1'b0;
  logic pend1 = 1'b0;

  // Records n cycles (cycle k+1 .. k+n). It models the requesters and the
  // chips: req drops when its ack is seen and optionally rises again one
  // cycle later; bd_in carries rd_val while brd_n is low and 0xEE otherwise.
  task automatic capture(input int n);
    m_wcs = '0; m_scs = '0; m_rd = '0; m_wr = '0;
    m_oe = '0; m_ack0 = '0; m_ack1 = '0; m_busy = '0;
    b_m_cs = '0; b_m_rd = '0; b_m_wr = '0; b_m_ack = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge fclk);
      m_wcs[c]   = ~w5300_cs_n;
      m_scs[c]   = ~sl811_cs_n;
      m_rd[c]    = ~brd_n;
      m_wr[c]    = ~bwr_n;
      m_oe[c]    = bd_oe;
      m_ack0[c]  = r0_ack;
      m_ack1[c]  = r1_ack;
      m_busy[c]  = busy;
      t_bd[c]    = bd_out;
      t_r0d[c]   = r0_rdata;
      t_r1d[c]   = r1_rdata;
      t_addr[c]  = w5300_addr;
      t_a0[c]    = sl811_a0;
      b_m_cs[c]  = ~b_w5300_cs_n | ~b_sl811_cs_n;
      b_m_rd[c]  = ~b_brd_n;
      b_m_wr[c]  = ~b_bwr_n;
      b_m_ack[c] = b_r0_ack;
      b_t_r0d[c] = b_r0_rdata;
      if (pend0) begin r0_req = 1'b1; pend0 = 1'b0; end
      if (pend1) begin r1_req = 1'b1; pend1 = 1'b0; end
      if (r0_ack) begin
        r0_req = 1'b0;
        if (rearm0 > 0) begin rearm0--; pend0 = 1'b1; end
      end
      if (r1_ack) begin
        r1_req = 1'b0;
        if (rearm1 > 0) begin rearm1--; pend1 = 1'b1; end
      end
      if (b_r0_ack) b_r0_req = 1'b0;
      bd_in   = !brd_n   ? rd_val : 8'hEE;
      b_bd_in = !b_brd_n ? rd_val : 8'hEE;
      @(posedge fclk);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    r0_req = 0; r0_we = 0; r0_sel = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_sel = 0; r1_addr = '0; r1_wdata = '0;
    b_r0_req = 0; b_r0_we = 0; b_r0_sel = 0; b_r0_addr = '0; b_r0_wdata = '0;
    b_r1_req = 0; b_r1_we = 0; b_r1_sel = 0; b_r1_addr = '0; b_r1_wdata = '0;
    bd_in = 8'hEE; b_bd_in = 8'hEE; rd_val = 8'h00;
    #12;
    total++; if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n} !== 4'b1111) begin
      bad++; $display("FAIL reset_cs_strobe: got %b want 1111",
                      {w5300_cs_n, sl811_cs_n, brd_n, bwr_n});
    end
    total++; if ({bd_oe, r0_ack, r1_ack, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_oe_ack_busy: got %b want 0000",
                      {bd_oe, r0_ack, r1_ack, busy});
    end
    total++; if ({w5300_addr, sl811_a0, bd_out} !== 19'd0) begin
      bad++; $display("FAIL reset_addr_bd: got %h %b %h want 0 0 0",
                      w5300_addr, sl811_a0, bd_out);
    end
    total++; if ({r0_rdata, r1_rdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 00 00",
                      r0_rdata, r1_rdata);
    end
    @(negedge fclk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write();
    @(negedge fclk);
    r0_we = 1; r0_sel = 0; r0_addr = 10'h3FF; r0_wdata = 8'hA5; r0_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (t_addr[1] !== 10'h3FF) begin
      bad++; $display("FAIL wr_addr: got %h want 3ff", t_addr[1]);
    end
    total++; if (m_wcs !== 96'h7E) begin
      bad++; $display("FAIL wr_wcs: got %h want 7e", m_wcs);
    end
    total++; if (m_wr !== 96'h3C) begin
      bad++; $display("FAIL wr_bwr: got %h want 3c", m_wr);
    end
    total++; if (m_oe !== 96'h7E) begin
      bad++; $display("FAIL wr_oe: got %h want 7e", m_oe);
    end
    for (int c = 1; c <= 6; c++) begin
      total++; if (t_bd[c] !== 8'hA5) begin
        bad++; $display("FAIL wr_bd_c%0d: got %h want a5", c, t_bd[c]);
      end
    end
    total++; if (m_ack0 !== 96'h80) begin
      bad++; $display("FAIL wr_ack0: got %h want 80", m_ack0);
    end
    total++; if ({m_scs, m_rd, m_ack1} !== '0) begin
      bad++; $display("FAIL wr_quiet: scs=%h rd=%h ack1=%h want 0",
                      m_scs, m_rd, m_ack1);
    end
    total++; if (m_busy !== 96'hFE) begin
      bad++; $display("FAIL wr_busy: got %h want fe", m_busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_read();
    // r0 read from the W5300
    @(negedge fclk);
    rd_val = 8'h96;
    r0_we = 0; r0_sel = 0; r0_addr = 10'h012; r0_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (t_r0d[7] !== 8'h96) begin
      bad++; $display("FAIL rd0_data: got %h want 96", t_r0d[7]);
    end
    total++; if (m_rd !== 96'h3C || m_wr !== '0) begin
      bad++; $display("FAIL rd0_strobe: rd=%h wr=%h want 3c 0", m_rd, m_wr);
    end
    total++; if (t_addr[1] !== 10'h012) begin
      bad++; $display("FAIL rd0_addr: got %h want 012", t_addr[1]);
    end
    // r1 read from the SL811
    @(negedge fclk);
    rd_val = 8'h5C;
    r1_we = 0; r1_sel = 1; r1_addr = 10'h001; r1_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (t_a0[1] !== 1'b1) begin
      bad++; $display("FAIL rd1_a0: got %b want 1", t_a0[1]);
    end
    total++; if (m_scs !== 96'h7E || m_wcs !== '0) begin
      bad++; $display("FAIL rd1_cs: scs=%h wcs=%h want 7e 0", m_scs, m_wcs);
    end
    total++; if (m_rd !== 96'h3C) begin
      bad++; $display("FAIL rd1_brd: got %h want 3c", m_rd);
    end
    total++; if (m_oe !== '0) begin
      bad++; $display("FAIL rd1_oe: got %h want 0", m_oe);
    end
    total++; if (m_ack1 !== 96'h80 || m_ack0 !== '0) begin
      bad++; $display("FAIL rd1_ack: ack1=%h ack0=%h want 80 0", m_ack1, m_ack0);
    end
    total++; if (t_r1d[7] !== 8'h5C) begin
      bad++; $display("FAIL rd1_data: got %h want 5c", t_r1d[7]);
    end
    total++; if (t_r0d[10] !== 8'h96) begin
      bad++; $display("FAIL rd1_r0_kept: got %h want 96", t_r0d[10]);
    end
    total++; if (t_addr[10] !== 10'h012) begin
      bad++; $display("FAIL rd1_waddr_kept: got %h want 012", t_addr[10]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [95:0] e_ack0, e_ack1, e_wcs, e_scs;
    @(negedge fclk); rst_n = 1'b0;
    @(negedge fclk); rst_n = 1'b1;
    @(negedge fclk);
    r0_we = 1; r0_sel = 0; r0_addr = 10'h010; r0_wdata = 8'h11;
    r1_we = 1; r1_sel = 1; r1_addr = 10'h000; r1_wdata = 8'h22;
    rearm0 = 3; rearm1 = 3;
    r0_req = 1; r1_req = 1;
    @(posedge fclk);
    capture(64);
    // Expected: r0 starts at k+16i, r1 at k+8+16i, each access spans 8 cycles.
    e_ack0 = '0; e_ack1 = '0; e_wcs = '0; e_scs = '0;
    for (int i = 0; i < 4; i++) begin
      e_ack0[7 + 16*i]  = 1'b1;
      e_ack1[15 + 16*i] = 1'b1;
      for (int j = 1; j <= 6; j++) begin
        e_wcs[j + 16*i]     = 1'b1;
        e_scs[j + 8 + 16*i] = 1'b1;
      end
    end
    total++; if (m_ack0 !== e_ack0) begin
      bad++; $display("FAIL rr_ack0: got %h want %h", m_ack0, e_ack0);
    end
    total++; if (m_ack1 !== e_ack1) begin
      bad++; $display("FAIL rr_ack1: got %h want %h", m_ack1, e_ack1);
    end
    total++; if (m_wcs !== e_wcs) begin
      bad++; $display("FAIL rr_wcs: got %h want %h", m_wcs, e_wcs);
    end
    total++; if (m_scs !== e_scs) begin
      bad++; $display("FAIL rr_scs: got %h want %h", m_scs, e_scs);
    end
    total++; if ((m_wcs & m_scs) !== '0) begin
      bad++; $display("FAIL rr_cs_overlap: got %h want 0", m_wcs & m_scs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_abort();
    @(negedge fclk);
    r0_we = 1; r0_sel = 0; r0_addr = 10'h0AB; r0_wdata = 8'h3C; r0_req = 1;
    @(posedge fclk);                 // edge k
    @(negedge fclk); @(posedge fclk); // cycle k+1
    @(negedge fclk); @(posedge fclk); // cycle k+2
    @(negedge fclk);                  // cycle k+3 = second strobe cycle
    total++; if (bwr_n !== 1'b0) begin
      bad++; $display("FAIL ab_strobe_before: got %b want 0", bwr_n);
    end
    rst_n = 1'b0;
    #1;
    total++; if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n} !== 4'b1111) begin
      bad++; $display("FAIL ab_cs_strobe: got %b want 1111",
                      {w5300_cs_n, sl811_cs_n, brd_n, bwr_n});
    end
    total++; if ({bd_oe, busy} !== 2'b00 || bd_out !== 8'h00) begin
      bad++; $display("FAIL ab_oe_bd: oe=%b busy=%b bd=%h want 0 0 00",
                      bd_oe, busy, bd_out);
    end
    r0_req = 1'b0;
    capture(4);
    total++; if ((m_ack0 | m_ack1) !== '0) begin
      bad++; $display("FAIL ab_no_ack: got %h want 0", m_ack0 | m_ack1);
    end
    @(negedge fclk);
    rst_n = 1'b1;
    @(negedge fclk);
    r0_we = 1; r0_sel = 0; r0_addr = 10'h100; r0_wdata = 8'h81; r0_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (m_wcs !== 96'h7E || m_wr !== 96'h3C) begin
      bad++; $display("FAIL ab_after_cs_wr: wcs=%h wr=%h want 7e 3c", m_wcs, m_wr);
    end
    total++; if (m_ack0 !== 96'h80 || t_addr[1] !== 10'h100 || t_bd[3] !== 8'h81) begin
      bad++; $display("FAIL ab_after_ack: ack0=%h addr=%h bd=%h want 80 100 81",
                      m_ack0, t_addr[1], t_bd[3]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drop_req();
    @(negedge fclk);
    rd_val = 8'h42;
    r0_we = 0; r0_sel = 0; r0_addr = 10'h155; r0_req = 1;
    @(posedge fclk);     // edge k
    @(negedge fclk);     // cycle k+1 (SETUP)
    r0_req = 1'b0;
    r0_addr = 10'h2AA;
    @(posedge fclk);
    capture(12);         // c = 1 is cycle k+2
    total++; if (m_wcs !== 96'h3E) begin
      bad++; $display("FAIL dr_wcs: got %h want 3e", m_wcs);
    end
    total++; if (m_ack0 !== 96'h40) begin
      bad++; $display("FAIL dr_ack0: got %h want 40", m_ack0);
    end
    total++; if (t_addr[1] !== 10'h155 || t_addr[12] !== 10'h155) begin
      bad++; $display("FAIL dr_addr: got %h %h want 155 155", t_addr[1], t_addr[12]);
    end
    total++; if (t_r0d[6] !== 8'h42) begin
      bad++; $display("FAIL dr_rdata: got %h want 42", t_r0d[6]);
    end
    total++; if (m_busy !== 96'h7E) begin
      bad++; $display("FAIL dr_busy: got %h want 7e", m_busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timing_213();
    @(negedge fclk);
    b_r0_we = 1; b_r0_sel = 0; b_r0_addr = 10'h002; b_r0_wdata = 8'h11;
    b_r0_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (b_m_cs !== 96'h7E) begin
      bad++; $display("FAIL t2_wr_cs: got %h want 7e", b_m_cs);
    end
    total++; if (b_m_wr !== 96'h08 || b_m_rd !== '0) begin
      bad++; $display("FAIL t2_wr_strobe: wr=%h rd=%h want 08 0", b_m_wr, b_m_rd);
    end
    total++; if (b_m_ack !== 96'h80) begin
      bad++; $display("FAIL t2_wr_ack: got %h want 80", b_m_ack);
    end
    @(negedge fclk);
    rd_val = 8'h77;
    b_r0_we = 0; b_r0_sel = 1; b_r0_addr = 10'h003; b_r0_req = 1;
    @(posedge fclk);
    capture(10);
    total++; if (b_m_rd !== 96'h08 || b_m_cs !== 96'h7E) begin
      bad++; $display("FAIL t2_rd_strobe_cs: rd=%h cs=%h want 08 7e", b_m_rd, b_m_cs);
    end
    total++; if (b_m_ack !== 96'h80 || b_t_r0d[7] !== 8'h77) begin
      bad++; $display("FAIL t2_rd_ack_data: ack=%h data=%h want 80 77",
                      b_m_ack, b_t_r0d[7]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_abort();
    test_drop_req();
    test_timing_213();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
